// File: rtl/moxie_wb_pkg.sv
// Shared Wishbone constants, arbiter state encoding and request bundle for the Moxie I/D arbiter.
package moxie_wb_pkg;

  localparam int WB_ADR_W       = 32;
  localparam int WB_DAT_W       = 16;
  localparam int WB_SEL_W       = 2;
  localparam int WB_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  // One master's view of the external bus request, muxed as a unit.
  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
  } wb_req_t;

  function automatic arb_state_e gnt_state(input logic pick_d);
    return pick_d ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: counts consecutive unacked strobe cycles, fires on the TIMEOUT-th one.
// Latency: fire is combinational in the tripping cycle; the counter updates on the next edge.
// Backpressure: none; it only observes the bus handshake.
module wb_watchdog
  import moxie_wb_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic stb,
  input  logic ack,
  output logic fire
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt;
  logic        wait_cyc;

  assign wait_cyc = stb & ~ack;
  assign fire     = wait_cyc && (wd_cnt == WD_LAST);

  // The owner releases the bus when fire is seen, so clr wraps the count before it can overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr || ack) begin
      wd_cnt <= '0;
    end else if (wait_cyc) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/wb_id_arbiter.sv
// wb_id_arbiter: registered grant FSM steering the Moxie I/D Wishbone ports onto one 16-bit bus.
// Latency: grant one edge after cyc in IDLE; data/ack pass combinationally. Backpressure: loser waits, no preemption.
// Tie policy: WB_ARB_ROUND_ROBIN_EN defined alternates on ties, otherwise D always wins a tie.
module wb_id_arbiter
  import moxie_wb_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic [WB_ADR_W-1:0] wb_I_adr_i,
  input  logic                wb_I_cyc_i,
  input  logic                wb_I_stb_i,
  output logic [WB_DAT_W-1:0] wb_I_dat_o,
  output logic                wb_I_ack_o,
  output logic                wb_I_err_o,

  input  logic [WB_ADR_W-1:0] wb_D_adr_i,
  input  logic [WB_DAT_W-1:0] wb_D_dat_i,
  input  logic [WB_SEL_W-1:0] wb_D_sel_i,
  input  logic                wb_D_we_i,
  input  logic                wb_D_cyc_i,
  input  logic                wb_D_stb_i,
  output logic [WB_DAT_W-1:0] wb_D_dat_o,
  output logic                wb_D_ack_o,
  output logic                wb_D_err_o,

  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i
);

  arb_state_e state;
  wb_req_t    i_req, d_req, bus_req;
  logic       own_cyc;
  logic       pick_d;
  logic       wd_fire;
  logic       wd_clr;
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic       last_gnt_d;
`endif

  // I only ever fetches full halfwords.
  assign i_req = '{adr: wb_I_adr_i, dat: '0, sel: {WB_SEL_W{1'b1}}, we: 1'b0,
                   cyc: wb_I_cyc_i, stb: wb_I_stb_i};
  assign d_req = '{adr: wb_D_adr_i, dat: wb_D_dat_i, sel: wb_D_sel_i, we: wb_D_we_i,
                   cyc: wb_D_cyc_i, stb: wb_D_stb_i};

  always_comb begin
    bus_req = '0;
    case (state)
      GNT_I:   bus_req = i_req;
      GNT_D:   bus_req = d_req;
      default: bus_req = '0;
    endcase
  end

  assign own_cyc = bus_req.cyc;

`ifdef WB_ARB_ROUND_ROBIN_EN
  assign pick_d = wb_D_cyc_i & (~wb_I_cyc_i | ~last_gnt_d);
`else
  assign pick_d = wb_D_cyc_i;
`endif

  // Owner leaving (cyc drop or timeout) and IDLE both restart the timeout window.
  assign wd_clr = ~own_cyc | wd_fire;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (wd_clr),
    .stb   (bus_req.stb),
    .ack   (wb_ack_i),
    .fire  (wd_fire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_gnt_d <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wb_I_cyc_i || wb_D_cyc_i) begin
            state      <= gnt_state(pick_d);
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_gnt_d <= pick_d;
`endif
          end
        end
        GNT_I, GNT_D: begin
          if (!own_cyc || wd_fire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_adr_o = bus_req.adr;
  assign wb_dat_o = bus_req.dat;
  assign wb_sel_o = bus_req.sel;
  assign wb_we_o  = bus_req.we;
  assign wb_cyc_o = bus_req.cyc;
  assign wb_stb_o = bus_req.stb;

  // A slave ack seen in IDLE has no strobe behind it and is dropped here.
  assign wb_I_ack_o = (state == GNT_I) & wb_ack_i & bus_req.stb;
  assign wb_D_ack_o = (state == GNT_D) & wb_ack_i & bus_req.stb;
  assign wb_I_err_o = (state == GNT_I) & wd_fire;
  assign wb_D_err_o = (state == GNT_D) & wd_fire;

  assign wb_I_dat_o = wb_dat_i;
  assign wb_D_dat_o = wb_dat_i;

endmodule

// File: tb/tb_wb_id_arbiter.sv
// Bench for wb_id_arbiter: directed scenarios plus random traffic against an ownership-level model.
module tb_wb_id_arbiter;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wb_I_adr_i;
  logic        wb_I_cyc_i, wb_I_stb_i;
  logic [15:0] wb_I_dat_o;
  logic        wb_I_ack_o, wb_I_err_o;
  logic [31:0] wb_D_adr_i;
  logic [15:0] wb_D_dat_i;
  logic [1:0]  wb_D_sel_i;
  logic        wb_D_we_i, wb_D_cyc_i, wb_D_stb_i;
  logic [15:0] wb_D_dat_o;
  logic        wb_D_ack_o, wb_D_err_o;
  logic [31:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;

  always #5 clk_i = ~clk_i;

  wb_id_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_I_adr_i(wb_I_adr_i), .wb_I_cyc_i(wb_I_cyc_i), .wb_I_stb_i(wb_I_stb_i),
    .wb_I_dat_o(wb_I_dat_o), .wb_I_ack_o(wb_I_ack_o), .wb_I_err_o(wb_I_err_o),
    .wb_D_adr_i(wb_D_adr_i), .wb_D_dat_i(wb_D_dat_i), .wb_D_sel_i(wb_D_sel_i),
    .wb_D_we_i(wb_D_we_i), .wb_D_cyc_i(wb_D_cyc_i), .wb_D_stb_i(wb_D_stb_i),
    .wb_D_dat_o(wb_D_dat_o), .wb_D_ack_o(wb_D_ack_o), .wb_D_err_o(wb_D_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: who owns the bus (0 none, 1 I, 2 D) and how many unacked strobes in a row.
  int m_own = 0;
  int m_wd  = 0;
`ifdef WB_ARB_ROUND_ROBIN_EN
  bit m_last_d = 1'b0;
`endif
  logic i_done = 1'b0;
  logic d_done = 1'b0;

  task automatic check_cycle();
    logic [31:0] e_adr;
    logic [15:0] e_dat;
    logic [1:0]  e_sel;
    logic        e_we, e_cyc, e_stb, e_fire;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    if (m_own == 1) begin
      e_adr = wb_I_adr_i; e_sel = 2'b11; e_cyc = wb_I_cyc_i; e_stb = wb_I_stb_i;
    end else if (m_own == 2) begin
      e_adr = wb_D_adr_i; e_dat = wb_D_dat_i; e_sel = wb_D_sel_i; e_we = wb_D_we_i;
      e_cyc = wb_D_cyc_i; e_stb = wb_D_stb_i;
    end
    e_fire = e_stb && !wb_ack_i && (m_wd == TO - 1);
    chk("bus_adr", wb_adr_o, e_adr);
    chk("bus_dat", wb_dat_o, e_dat);
    chk("bus_sel", wb_sel_o, e_sel);
    chk("bus_we",  wb_we_o,  e_we);
    chk("bus_cyc", wb_cyc_o, e_cyc);
    chk("bus_stb", wb_stb_o, e_stb);
    chk("i_ack", wb_I_ack_o, (m_own == 1) && wb_ack_i && e_stb);
    chk("d_ack", wb_D_ack_o, (m_own == 2) && wb_ack_i && e_stb);
    chk("i_err", wb_I_err_o, (m_own == 1) && e_fire);
    chk("d_err", wb_D_err_o, (m_own == 2) && e_fire);
    chk("i_rdat", wb_I_dat_o, wb_dat_i);
    chk("d_rdat", wb_D_dat_o, wb_dat_i);
  endtask

  task automatic update_model();
    logic o_cyc, o_stb;
    if (rst_i) begin
      m_own = 0; m_wd = 0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      m_last_d = 1'b0;
`endif
    end else if (m_own == 0) begin
      m_wd = 0;
      if (wb_I_cyc_i && wb_D_cyc_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        m_own = m_last_d ? 1 : 2;
`else
        m_own = 2;
`endif
      end else if (wb_D_cyc_i) m_own = 2;
      else if (wb_I_cyc_i) m_own = 1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      if (m_own != 0) m_last_d = (m_own == 2);
`endif
    end else begin
      o_cyc = (m_own == 1) ? wb_I_cyc_i : wb_D_cyc_i;
      o_stb = (m_own == 1) ? wb_I_stb_i : wb_D_stb_i;
      if (!o_cyc || (o_stb && !wb_ack_i && m_wd == TO - 1)) begin
        m_own = 0; m_wd = 0;
      end else if (wb_ack_i) m_wd = 0;
      else if (o_stb) m_wd++;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1 check_cycle();
    i_done = wb_I_ack_o | wb_I_err_o;
    d_done = wb_D_ack_o | wb_D_err_o;
    @(posedge clk_i);
    update_model();
    @(negedge clk_i);
  endtask

  initial begin
    int ack_pct;
    rst_i = 1'b1; wb_ack_i = 1'b0; wb_dat_i = '0;
    wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_I_adr_i = 32'h100;
    wb_D_cyc_i = 1'b1; wb_D_stb_i = 1'b1; wb_D_adr_i = 32'h200;
    wb_D_we_i = 1'b1; wb_D_sel_i = 2'b10; wb_D_dat_i = 16'h55AA;
    @(posedge clk_i);
    @(negedge clk_i);

    // Reset held with both masters requesting, then D wins on release.
    step();
    rst_i = 1'b0;
    #1 chk("rst_rel_cyc", wb_cyc_o, 1'b0);
    chk("rst_rel_adr", wb_adr_o, 32'h0);
    step();
    #1 chk("rst_gnt_cyc", wb_cyc_o, 1'b1);
    chk("rst_gnt_adr", wb_adr_o, 32'h200);
    wb_ack_i = 1'b1; wb_dat_i = 16'hA5A5;
    step();
    wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0; wb_ack_i = 1'b0;
    step();
    step();
    wb_ack_i = 1'b1;
    step();
    wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0; wb_ack_i = 1'b0;
    step(); step();

    // Single I read acked after three wait cycles.
    wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_I_adr_i = 32'h0000_1000;
    step();
    #1 chk("ird_adr", wb_adr_o, 32'h1000);
    chk("ird_sel", wb_sel_o, 2'b11);
    chk("ird_we", wb_we_o, 1'b0);
    step(); step(); step();
    wb_ack_i = 1'b1; wb_dat_i = 16'hBEEF;
    #1 chk("ird_ack", wb_I_ack_o, 1'b1);
    chk("ird_dat", wb_I_dat_o, 16'hBEEF);
    chk("ird_err", wb_I_err_o, 1'b0);
    chk("ird_dack", wb_D_ack_o, 1'b0);
    step();
    wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0; wb_ack_i = 1'b0;
    step(); step();

    // D byte write, then idle bus after the release.
    wb_D_cyc_i = 1'b1; wb_D_stb_i = 1'b1; wb_D_adr_i = 32'h2002;
    wb_D_dat_i = 16'h1234; wb_D_sel_i = 2'b01; wb_D_we_i = 1'b1;
    step();
    #1 chk("dwr_adr", wb_adr_o, 32'h2002);
    chk("dwr_dat", wb_dat_o, 16'h1234);
    chk("dwr_sel", wb_sel_o, 2'b01);
    chk("dwr_we", wb_we_o, 1'b1);
    wb_ack_i = 1'b1;
    step();
    wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0; wb_ack_i = 1'b0;
    step();
    #1 chk("dwr_idle_adr", wb_adr_o, 32'h0);
    step();

    // No preemption: D waits until two cycles after I drops cyc.
    wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_I_adr_i = 32'h3000;
    step();
    wb_D_cyc_i = 1'b1; wb_D_stb_i = 1'b1; wb_D_adr_i = 32'h4000;
    step(); step();
    wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0;
    #1 chk("np_hold_adr", wb_adr_o, 32'h3000);
    step();
    #1 chk("np_gap_cyc", wb_cyc_o, 1'b0);
    step();
    #1 chk("np_gnt_adr", wb_adr_o, 32'h4000);
    chk("np_gnt_cyc", wb_cyc_o, 1'b1);
    wb_ack_i = 1'b1;
    step();
    wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0; wb_ack_i = 1'b0;
    step(); step();

    // Watchdog: I strobes with no ack; err only in the TO-th strobe cycle.
    wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_I_adr_i = 32'h5000;
    step();
    for (int k = 1; k <= TO; k++) begin
      #1 chk("wd_err", wb_I_err_o, logic'(k == TO));
      step();
    end
    wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0; wb_ack_i = 1'b1;
    #1 chk("wd_after_cyc", wb_cyc_o, 1'b0);
    chk("wd_late_iack", wb_I_ack_o, 1'b0);
    chk("wd_late_dack", wb_D_ack_o, 1'b0);
    step();
    wb_ack_i = 1'b0;
    step();

    // Continuous tie: each winner drops cyc for one cycle and re-requests.
    wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_D_cyc_i = 1'b1; wb_D_stb_i = 1'b1;
    wb_ack_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int who;
      int exp_who;
      who = 0;
      for (int k = 0; k < 6 && who == 0; k++) begin
        step();
        if (d_done) who = 2;
        else if (i_done) who = 1;
      end
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_who = (r % 2 == 0) ? 2 : 1;
`else
      exp_who = 2;
`endif
      chk("tie_order", who, exp_who);
      if (who == 2) begin wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0; end
      else if (who == 1) begin wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0; end
      step();
      wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_D_cyc_i = 1'b1; wb_D_stb_i = 1'b1;
    end
    wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0; wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0;
    wb_ack_i = 1'b0;
    step(); step();

    // Random traffic with occasional mid-cycle resets and stray acks.
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ack_pct = int'($urandom_range(95, 20));
      rst_i = ($urandom_range(299) == 0);
      if (wb_I_cyc_i) begin
        if (i_done) begin wb_I_cyc_i = 1'b0; wb_I_stb_i = 1'b0; end
      end else if ($urandom_range(2) == 0) begin
        wb_I_cyc_i = 1'b1; wb_I_stb_i = 1'b1; wb_I_adr_i = $urandom;
      end
      if (wb_D_cyc_i) begin
        if (d_done) begin wb_D_cyc_i = 1'b0; wb_D_stb_i = 1'b0; end
      end else if ($urandom_range(2) == 0) begin
        wb_D_cyc_i = 1'b1; wb_D_stb_i = 1'b1; wb_D_adr_i = $urandom;
        wb_D_dat_i = 16'($urandom); wb_D_sel_i = 2'($urandom_range(3));
        wb_D_we_i = 1'($urandom_range(1));
      end
      wb_ack_i = (int'($urandom_range(99)) < ack_pct);
      wb_dat_i = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_id_arbiter.md
# wb_id_arbiter

Two-master Wishbone arbiter between the Moxie core's instruction-fetch port (I) and data port (D) and the single 16-bit external Wishbone bus. It sits directly downstream of the core top level, replacing the combinational I/D steering with a registered grant FSM. The FSM holds ownership for a master's whole bus cycle and terminates hung slave accesses with an error pulse.

## Interface
- `TIMEOUT`, default 64: number of cycles `wb_stb_o` may stay high without `wb_ack_i` before the watchdog fires; legal range is 2..65535.
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset. One clock domain; reset is synchronous and active-high.
- `wb_I_adr_i` in 32 / `wb_I_cyc_i` in 1 / `wb_I_stb_i` in 1: I master request. I is always a read with `sel` = 2'b11.
- `wb_I_dat_o` out 16 / `wb_I_ack_o` out 1 / `wb_I_err_o` out 1: I master response.
- `wb_D_adr_i` in 32 / `wb_D_dat_i` in 16 / `wb_D_sel_i` in 2 / `wb_D_we_i` in 1 / `wb_D_cyc_i` in 1 / `wb_D_stb_i` in 1: D master request.
- `wb_D_dat_o` out 16 / `wb_D_ack_o` out 1 / `wb_D_err_o` out 1: D master response.
- `wb_adr_o` out 32 / `wb_dat_o` out 16 / `wb_sel_o` out 2 / `wb_we_o` out 1 / `wb_cyc_o` out 1 / `wb_stb_o` out 1: external bus request.
- `wb_dat_i` in 16 / `wb_ack_i` in 1: external bus response.

## Operation
- FSM states are IDLE, GNT_I and GNT_D. The state register resets to IDLE.
- **IDLE**
  - Only I requesting (`wb_I_cyc_i`): go to GNT_I.
  - Only D requesting (`wb_D_cyc_i`): go to GNT_D.
  - Both requesting: the arbitration rule decides (see Configuration).
  - Neither requesting: stay in IDLE.
- **GNT_x**
  - Stay while `wb_x_cyc_i` = 1.
  - Go to IDLE when `wb_x_cyc_i` = 0, or when the watchdog fires.
  - The other master's request is never considered until IDLE. There is no preemption.
- **Outputs in GNT_x**
  - `wb_adr_o`, `wb_cyc_o` and `wb_stb_o` mirror master x.
  - For D: `wb_dat_o`, `wb_sel_o` and `wb_we_o` mirror D.
  - For I: `wb_dat_o` = 0, `wb_sel_o` = 2'b11, `wb_we_o` = 0.
  - `wb_x_ack_o` = `wb_ack_i & wb_stb_o`. The non-granted master's ack and err are 0.
- **Outputs in IDLE:** all bus outputs are 0 (adr, dat, sel, we, cyc, stb).
- **Read data:** `wb_I_dat_o` and `wb_D_dat_o` both equal `wb_dat_i` at all times. Masters qualify it with ack.
- **Watchdog**
  - 16-bit counter `wd_cnt`, reset to 0.
  - Increments on each cycle with `wb_stb_o & !wb_ack_i`.
  - Clears on ack, in IDLE, and on a state change.
  - When `wd_cnt == TIMEOUT-1` and `wb_stb_o & !wb_ack_i`: `wb_x_err_o` = 1 for that one cycle (combinational), and the next state is IDLE.
- **Late ack:** a slave ack arriving while in IDLE is dropped and not routed to any master.
- **Reset mid-cycle:** on the reset edge the state goes to IDLE, and `wd_cnt` and the last-grant register clear. All outputs are 0 in the cycle after that edge regardless of master cyc. Masters must re-issue.

## Timing
- Grant latency: master cyc rises in cycle N while in IDLE → grant register is set at edge N+1 → `wb_cyc_o` and `wb_stb_o` are high in cycle N+1.
- Master-side outputs are combinational from the registered state. There is no added data latency; ack is returned in the same cycle as `wb_ack_i`.
- Release: master drops cyc in cycle M → state is IDLE in M+1 → the earliest next grant is visible in M+2. This gives one dead bus cycle between owners.
- Back-to-back cycles by the same master also pay one IDLE cycle. The master must drop cyc for ≥1 cycle between cycles.
- Watchdog: with `TIMEOUT` = T, err is asserted in the T-th consecutive unacked strobe cycle. `wb_cyc_o` is 0 in the following cycle.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant register is updated on each IDLE→GNT transition. It resets to I, so D wins the first tie.
  - On a tie, the master not granted last wins.
- `WB_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, D over I, on every tie. This keeps loads and stores from stalling behind instruction prefetch.
  - No last-grant register exists.

## Structure
- Shared package `moxie_wb_pkg` holds:
  - the state encoding (IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2);
  - the `WB_ADR_W` = 32, `WB_DAT_W` = 16 and `WB_SEL_W` = 2 constants;
  - the default `TIMEOUT`.
- One sub-module: `wb_watchdog` (counter, compare, fire output), parameterised by `TIMEOUT`. The FSM and muxes stay in `wb_id_arbiter`.

## Test plan
- Reset: hold `rst_i` 2 cycles with both cyc high → all outputs 0 and `wb_cyc_o` = 0 in the first cycle after release. `wb_cyc_o` rises the next cycle with D granted.
- Single I read: I cyc/stb at adr 0x0000_1000; slave acks after 3 cycles with 0xBEEF → `wb_adr_o` = 0x1000, `wb_sel_o` = 2'b11, `wb_we_o` = 0; `wb_I_ack_o` = 1 with `wb_I_dat_o` = 0xBEEF; `wb_D_ack_o` = 0 throughout.
- D write: adr 0x2002, dat 0x1234, sel 2'b01 → bus shows the same values with `wb_we_o` = 1. After the ack and cyc drop, state is IDLE the next cycle.
- Tie, fixed priority: both request continuously for 4 cycles each → grants D, I… in fixed mode D wins every tie. With `WB_ARB_ROUND_ROBIN_EN` the sequence alternates D, I, D, I.
- No preemption: D requests while I is mid-cycle → D is not granted until 2 cycles after I drops cyc.
- Watchdog: `TIMEOUT` = 4, I strobes, slave never acks → `wb_I_err_o` is high only in the 4th stb cycle, `wb_cyc_o` is 0 the next cycle, and a late ack in IDLE is not routed.
